// File: rtl/io_input_pkg.sv
// Shared byte-level types for the UART receive path.
package io_input_pkg;
  localparam int IO_BYTE_W = 8;
  typedef logic [IO_BYTE_W-1:0] io_byte_t;
endpackage

// File: rtl/io_input_fifo_if.sv
// Receive FIFO bus: producer strobe, FWFT consumer handshake and status.
// IO_INPUT_FIFO_DROP_CNT_EN adds the drop_count status field.
interface io_input_fifo_if #(parameter int DEPTH = 16);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                    io_input_trigger;
  io_input_pkg::io_byte_t  io_input_value;
  logic                    out_valid;
  io_input_pkg::io_byte_t  out_value;
  logic                    out_ready;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    overflow;
  logic                    overflow_clear;
`ifdef IO_INPUT_FIFO_DROP_CNT_EN
  logic [7:0]              drop_count;
`endif

  modport master (
    output io_input_trigger, io_input_value, out_ready, overflow_clear,
`ifdef IO_INPUT_FIFO_DROP_CNT_EN
    input  drop_count,
`endif
    input  out_valid, out_value, count, full, overflow
  );

  modport slave (
    input  io_input_trigger, io_input_value, out_ready, overflow_clear,
`ifdef IO_INPUT_FIFO_DROP_CNT_EN
    output drop_count,
`endif
    output out_valid, out_value, count, full, overflow
  );
endinterface

// File: rtl/IO_BYTE_RAM.sv
// DEPTH x 8 simple dual-port storage: synchronous write, asynchronous read.
module IO_BYTE_RAM
  import io_input_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  io_byte_t         wdata,
  input  logic [PTR_W-1:0] raddr,
  output io_byte_t         rdata
);
  io_byte_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/io_input_fifo.sv
// First-word-fall-through receive byte FIFO with drop-on-full and sticky overflow.
// Define IO_INPUT_FIFO_DROP_CNT_EN to add a saturating 8-bit drop_count.
module io_input_fifo
  import io_input_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic            clk,
  input logic            reset,
  io_input_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wp, rp, rp_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             vld_q, full_q, ovf_q;
  io_byte_t         head_q, head_nxt, ram_rdata;
  logic             pop, push, drop;

  assign pop  = vld_q & bus.out_ready;
  assign push = bus.io_input_trigger & (~full_q | pop);
  assign drop = bus.io_input_trigger & ~push;

  assign rp_nxt = rp + PTR_W'(pop);

  always_comb begin
    cnt_nxt = cnt_q;
    if (push & ~pop)      cnt_nxt = cnt_q + CNT_W'(1);
    else if (pop & ~push) cnt_nxt = cnt_q - CNT_W'(1);
  end

  // Head is registered: if the FIFO is empty after this cycle's pop, the
  // only candidate for the next head is the byte being written now.
  always_comb begin
    head_nxt = ram_rdata;
    if (cnt_q == CNT_W'(pop)) head_nxt = bus.io_input_value;
  end

  IO_BYTE_RAM #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wp),
    .wdata (bus.io_input_value),
    .raddr (rp_nxt),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wp     <= '0;
      rp     <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      head_q <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      rp     <= rp_nxt;
      cnt_q  <= cnt_nxt;
      vld_q  <= (cnt_nxt != '0);
      full_q <= (cnt_nxt == CNT_W'(DEPTH));
      head_q <= head_nxt;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)                    ovf_q <= 1'b1;
      else if (bus.overflow_clear) ovf_q <= 1'b0;
    end
  end

`ifdef IO_INPUT_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (bus.overflow_clear)      drop_cnt_q <= 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end else if (bus.overflow_clear) begin
      drop_cnt_q <= '0;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`endif

  assign bus.out_valid = vld_q;
  assign bus.out_value = head_q;
  assign bus.count     = cnt_q;
  assign bus.full      = full_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_io_input_fifo.sv
// Randomized + directed bench for io_input_fifo against a queue-based model.
module tb_io_input_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  io_input_fifo_if #(.DEPTH(DEPTH)) bus ();

  io_input_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: a byte queue plus the two status values.
  logic [7:0] m_q[$];
  logic [7:0] got[$];
  bit         m_ovf = 1'b0;
  int         m_dc = 0;
  bit         model_ok = 1'b0;
  bit         m_pop, m_push, m_drop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_dc     = 0;
      model_ok = 1'b1;
    end else begin
      m_pop  = (m_q.size() != 0) && bus.out_ready;
      m_push = bus.io_input_trigger && ((m_q.size() < DEPTH) || m_pop);
      m_drop = bus.io_input_trigger && !m_push;
      if (m_pop) begin
        got.push_back(m_q[0]);
        void'(m_q.pop_front());
      end
      if (m_push) m_q.push_back(bus.io_input_value);
      if (m_drop) begin
        m_ovf = 1'b1;
        m_dc  = bus.overflow_clear ? 1 : (m_dc == 255 ? 255 : m_dc + 1);
      end else if (bus.overflow_clear) begin
        m_ovf = 1'b0;
        m_dc  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("out_value", 32'(bus.out_value), 32'(m_q[0]));
      chk("count", 32'(bus.count), 32'(m_q.size()));
      chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef IO_INPUT_FIFO_DROP_CNT_EN
      chk("drop_count", 32'(bus.drop_count), 32'(m_dc));
`endif
    end
  end

  task automatic drive(input bit t, input logic [7:0] v, input bit r, input bit c, input bit rs);
    bus.io_input_trigger = t;
    bus.io_input_value   = v;
    bus.out_ready        = r;
    bus.overflow_clear   = c;
    reset                = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int pushed, cyc;
    bit t;
    bus.io_input_trigger = 1'b0;
    bus.io_input_value   = '0;
    bus.out_ready        = 1'b0;
    bus.overflow_clear   = 1'b0;

    // Reset state
    drive(0, 8'h00, 0, 0, 1);
    drive(0, 8'h00, 0, 0, 1);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_value", 32'(bus.out_value), 0);
    drive(0, 8'h00, 0, 0, 0);

    // Single byte
    drive(1, 8'hA5, 0, 0, 0);
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_value", 32'(bus.out_value), 32'hA5);
    chk("single_count", 32'(bus.count), 1);
    drive(0, 8'h00, 1, 0, 0);
    chk("single_pop_valid", 32'(bus.out_valid), 0);
    chk("single_pop_count", 32'(bus.count), 0);

    // Ordering across pointer wrap
    got.delete();
    pushed = 0;
    cyc = 0;
    while (got.size() < 40 && cyc < 2000) begin
      t = (pushed < 40) && (m_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      drive(t, 8'(pushed), 1'($urandom_range(0, 1)), 0, 0);
      if (t) pushed++;
      cyc++;
    end
    chk("wrap_len", 32'(got.size()), 40);
    for (int i = 0; i < 40 && i < got.size(); i++) chk("wrap_order", 32'(got[i]), 32'(i));

    // Overflow on full
    drive(0, 8'h00, 0, 0, 1);
    got.delete();
    fill(8'h10);
    drive(1, 8'hEE, 0, 0, 0);
    chk("ovf_full", 32'(bus.full), 1);
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 16);
`ifdef IO_INPUT_FIFO_DROP_CNT_EN
    chk("ovf_drop_count", 32'(bus.drop_count), 1);
`endif
    drain();
    chk("ovf_drain_len", 32'(got.size()), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("ovf_drain_data", 32'(got[i]), 32'(8'h10 + i));

    // Full with simultaneous push/pop, then clear-vs-set
    drive(0, 8'h00, 0, 1, 0);
    chk("clear_alone", 32'(bus.overflow), 0);
    fill(8'h40);
    drive(1, 8'h5A, 1, 0, 0);
    chk("fullpp_overflow", 32'(bus.overflow), 0);
    chk("fullpp_count", 32'(bus.count), 16);
    drive(1, 8'hEE, 0, 1, 0);
    chk("clear_vs_set", 32'(bus.overflow), 1);
`ifdef IO_INPUT_FIFO_DROP_CNT_EN
    chk("clear_vs_set_dc", 32'(bus.drop_count), 1);
`endif
    got.delete();
    drain();
    chk("fullpp_first", 32'(got[0]), 32'h41);
    chk("fullpp_last", 32'(got[15]), 32'h5A);
    drive(0, 8'h00, 0, 1, 0);
    chk("clear_after", 32'(bus.overflow), 0);

`ifdef IO_INPUT_FIFO_DROP_CNT_EN
    // Saturation of the drop counter
    fill(8'h80);
    for (int i = 0; i < 260; i++) drive(1, 8'hFF, 0, 0, 0);
    chk("drop_count_sat", 32'(bus.drop_count), 255);
`endif

    // Reset mid-operation
    drive(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(1, 8'(8'h60 + i), 0, 0, 0);
    drive(1, 8'hEE, 0, 0, 1);
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_overflow", 32'(bus.overflow), 0);
    drive(1, 8'h3C, 0, 0, 0);
    chk("midrst_head", 32'(bus.out_value), 32'h3C);
    chk("midrst_head_valid", 32'(bus.out_valid), 1);

    // Random traffic, biased toward full to exercise drops
    for (int i = 0; i < 4000; i++) begin
      drive(1'($urandom_range(0, 2) != 0), 8'($urandom),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 499) == 0));
    end

    drive(0, 8'h00, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/io_input_fifo.md
# io_input_fifo

Receive-side byte buffer sitting directly downstream of the UART input controller. It captures every single-cycle `io_input_trigger` pulse with its `io_input_value` byte into a power-of-two FIFO. It presents the oldest byte to the CPU-side I/O logic over a first-word-fall-through valid/ready interface. Bytes arriving while the FIFO is full are dropped and flagged, so a slow consumer never corrupts stored data.

## Interface
- `DEPTH`, 16: number of byte slots; power of two, minimum 2.
- `PTR_W`, `$clog2(DEPTH)`: read/write pointer width (derived; do not override).
- `CNT_W`, `$clog2(DEPTH) + 1`: occupancy width (derived; do not override).

- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `io_input_trigger` in 1: one-cycle strobe; a received byte is valid this cycle.
- `io_input_value` in 8: received byte, sampled when the trigger is high.
- `out_valid` out 1: `out_value` holds the oldest stored byte.
- `out_value` out 8: head byte; don't-care when `out_valid` is 0.
- `out_ready` in 1: consumer accepts the head byte; a pop occurs when `out_valid & out_ready`.
- `count` out CNT_W: number of bytes stored, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `overflow` out 1: sticky; set when a byte was dropped.
- `overflow_clear` in 1: one-cycle request to clear `overflow`.

## Operation
- Storage: DEPTH x 8 array; write pointer `wp`, read pointer `rp`, both PTR_W wide and wrapping modulo DEPTH. Occupancy is held in the `count` register.
- Push: `io_input_trigger` high and (not full, or a pop occurs in the same cycle). The byte is written at `wp`, then `wp` increments.
- Pop: `out_valid & out_ready`. `rp` increments.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Full with trigger and pop in the same cycle: the write is accepted. The slot freed by the pop is reused, and there is no drop.
- Full with trigger and no pop: the byte is discarded, pointers and `count` are unchanged, and `overflow` is set to 1.
- `overflow_clear`: clears `overflow` to 0. If a drop occurs in the same cycle, the set wins and `overflow` stays 1.
- Empty with pop request: impossible, because `out_valid` is 0. `out_ready` is ignored while `out_valid` is 0.
- No bypass path: a byte written into an empty FIFO is not visible in the cycle it is written.
- Reset (including mid-operation) discards all stored bytes. The array contents need not be cleared.

## Timing
- Reset values: `out_valid`=0, `count`=0, `full`=0, `overflow`=0, `out_value`=8'h00, `wp`=`rp`=0.
- Write latency: trigger at cycle N, then `count` and `full` update at N+1. When the FIFO was empty, `out_valid`=1 with the byte on `out_value` at N+1.
- `out_valid`, `out_value`, `count`, `full` and `overflow` are all registered outputs.
- Pop at cycle N: the next byte is on `out_value` at N+1. If the FIFO becomes empty, `out_valid`=0 at N+1.
- Back-to-back: one push and one pop per cycle are sustained indefinitely at any occupancy 1..DEPTH.
- Pointer wrap from DEPTH-1 to 0 causes no bubble and no data loss.

## Configuration
- `IO_INPUT_FIFO_DROP_CNT_EN` defined: adds output `drop_count` [7:0].
  - Increments on every dropped byte and saturates at 255.
  - Resets to 0 on `reset` or `overflow_clear`. A drop in the same cycle as the clear sets it to 1.
- Not defined: the `drop_count` port and its register are absent. All other behaviour is identical.

## Structure
- Package `io_input_pkg`: byte width constant `IO_BYTE_W = 8` and typedef `io_byte_t` (logic [7:0]). The UART controller side will migrate to the same package.
- Sub-module `IO_BYTE_RAM`: DEPTH x 8 simple dual-port array (sync write, async read), instantiated once.
- Pointer, count, flag and handshake logic stays in `io_input_fifo`.

## Test plan
- Single byte: trigger with 8'hA5, `out_ready`=0 -> next cycle `out_valid`=1, `out_value`=8'hA5, `count`=1; pulse `out_ready` -> `out_valid`=0, `count`=0.
- Ordering and wrap: push 8'h00..8'h27 (40 bytes, DEPTH=16) interleaved with pops -> consumer sees 8'h00..8'h27 in order, with no gaps across pointer wrap.
- Overflow: fill 16 bytes with `out_ready`=0, then push 8'hEE -> `full`=1, `overflow`=1, `count`=16; drain yields the first 16 bytes only (no 8'hEE); with the macro, `drop_count`=1.
- Full with simultaneous push/pop: at `count`=16, trigger 8'h5A while popping -> `overflow` stays 0, `count`=16, and 8'h5A emerges last.
- Clear vs. set: `overflow_clear` alone -> `overflow`=0; `overflow_clear` in the same cycle as a drop -> `overflow`=1.
- Reset mid-operation: 5 bytes stored, assert `reset` for 1 cycle -> `out_valid`=0, `count`=0, `overflow`=0; next push 8'h3C appears as the head byte.
